inst_prefetch_buffer: RTL and testbench
=======================================

INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4; number of FIFO entries; legal values are powers of two from 2 to 8.
REQ-002 Parameter WORD_SIZE, default 16; width of addresses and instruction words.
REQ-003 Clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 Reset_N  input  1  reset; synchronous, active-low.
REQ-005 cpu_readM1  input  1  CPU instruction-fetch request.
REQ-006 cpu_address1  input  WORD_SIZE  address the CPU is requesting.
REQ-007 cpu_data1  output  WORD_SIZE  instruction word returned to the CPU.
REQ-008 cpu_inst_valid  output  1  cpu_data1 is valid for cpu_address1 in this cycle.
REQ-009 mem_readM1  output  1  instruction-memory read request.
REQ-010 mem_address1  output  WORD_SIZE  instruction-memory read address.
REQ-011 mem_data1  input  WORD_SIZE  instruction-memory read data.
REQ-012 mem_ack  input  1  mem_data1 is valid; ignored whenever mem_readM1=0.
REQ-013 num_flush  output  WORD_SIZE  saturating count of flushes.

Function
REQ-014 The FIFO SHALL hold DEPTH (address, data) pairs, with a count from 0 to DEPTH and a fetch_pc register that holds the next address to prefetch.
REQ-015 Hit: cpu_readM1=1, count>0 and head address == cpu_address1 -> cpu_inst_valid=1 and cpu_data1=head data combinationally in the same cycle, and the head is popped at the next edge.
REQ-016 Wait: cpu_readM1=1, count==0 and cpu_address1==fetch_pc -> cpu_inst_valid=0 and no flush.
REQ-017 Miss: any other cycle with cpu_readM1=1 -> FIFO cleared, fetch_pc <= cpu_address1, and num_flush incremented (saturating at all-ones).
REQ-018 When cpu_inst_valid=0, cpu_data1 SHALL be 0.
REQ-019 FSM states:
- IDLE: no request outstanding.
- FETCH: mem_readM1=1, mem_address1=fetch_pc held stable until mem_ack.
- DISCARD: mem_readM1=1, the outstanding response is to be dropped.
REQ-020 IDLE -> FETCH at the edge when count<DEPTH and no miss occurs this cycle; after a miss in IDLE, the request for the new fetch_pc is issued in the following cycle.
REQ-021 FETCH with mem_ack and no miss -> push (fetch_pc, mem_data1), fetch_pc <= fetch_pc+1 modulo 2^WORD_SIZE, then go to IDLE.
REQ-022 FETCH with a miss and no mem_ack -> DISCARD; FETCH with a miss and mem_ack in the same cycle -> data dropped, go to IDLE.
REQ-023 DISCARD with mem_ack -> data dropped, go to IDLE, and fetch_pc is unchanged.
REQ-024 A request SHALL only be issued when count<DEPTH, so a push never finds the FIFO full.
REQ-025 A simultaneous pop and push in one cycle SHALL leave count unchanged.
REQ-026 Zero-wait memory (mem_ack in the first FETCH cycle) SHALL sustain one push every two cycles.
REQ-027 fetch_pc wrap from 0xFFFF to 0x0000 SHALL be seamless, with no flush.

Reset
REQ-028 With Reset_N=0 at an edge: count=0, fetch_pc=0, state IDLE, num_flush=0.
REQ-029 While Reset_N=0: mem_readM1=0, mem_address1=0, cpu_inst_valid=0, cpu_data1=0.
REQ-030 Reset mid-FETCH SHALL abandon the request; a mem_ack in the cycle after reset SHALL be ignored because mem_readM1=0.

Configuration
REQ-031 Macro PREFETCH_BYPASS_EN: when defined, in FETCH with mem_ack, count==0, cpu_readM1=1 and cpu_address1==fetch_pc, then mem_data1 SHALL go directly to cpu_data1 with cpu_inst_valid=1 in that cycle; the entry is not pushed and fetch_pc still increments.
REQ-032 When PREFETCH_BYPASS_EN is undefined, that case pushes normally and the hit occurs one cycle later.

Verification
REQ-033 Reset, then a 1-cycle-latency memory returning data=addr^0xA5A5, CPU requests 0,1,2,3 in order -> cpu_data1=0xA5A5,0xA5A4,0xA5A7,0xA5A6; num_flush=0.
REQ-034 CPU idle for 20 cycles -> exactly 4 requests issued (addresses 0-3), then mem_readM1 stays 0; count=4.
REQ-035 FIFO holds 0-3 and the CPU requests 0x0040 -> same-cycle cpu_inst_valid=0, num_flush=1, next request to address 0x0040, first hit on 0x0040 returns memory data for 0x0040.
REQ-036 Miss while FETCH is outstanding with a 5-cycle mem_ack -> state DISCARD, the acked data is not delivered, and the next mem_address1 equals the new CPU address.
REQ-037 Flush to 0xFFFE, then CPU requests 0xFFFE, 0xFFFF, 0x0000 -> all hit, num_flush=1.
REQ-038 Reset_N=0 for 1 cycle mid-FETCH, with mem_ack one cycle later -> mem_readM1=0 and nothing pushed; the next request is to address 0.

Source files
------------

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch FIFO between the CPU fetch port and instruction memory.
// Define PREFETCH_BYPASS_EN to forward a returning word straight to a waiting CPU.
module inst_prefetch_buffer #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 cpu_readM1,
    input  logic [WORD_SIZE-1:0] cpu_address1,
    output logic [WORD_SIZE-1:0] cpu_data1,
    output logic                 cpu_inst_valid,
    output logic                 mem_readM1,
    output logic [WORD_SIZE-1:0] mem_address1,
    input  logic [WORD_SIZE-1:0] mem_data1,
    input  logic                 mem_ack,
    output logic [WORD_SIZE-1:0] num_flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } state_t;

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] fifo_addr [DEPTH];
    logic [WORD_SIZE-1:0] fifo_data [DEPTH];
    logic [AW-1:0]        head, tail;
    logic [CW-1:0]        count;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] flush_cnt;

    logic has_data, hit, wait_pc, miss;
    logic ack_live, take, push, bypass;

    // Classify the CPU request and the memory response for this cycle.
    always_comb begin
        has_data = (count != '0);
        hit      = cpu_readM1 && has_data && (fifo_addr[head] == cpu_address1);
        wait_pc  = cpu_readM1 && !has_data && (cpu_address1 == fetch_pc);
        miss     = cpu_readM1 && !hit && !wait_pc;
        ack_live = (state == FETCH) && mem_ack;
`ifdef PREFETCH_BYPASS_EN
        bypass   = ack_live && wait_pc;
`else
        bypass   = 1'b0;
`endif
        take     = ack_live && !miss;
        push     = take && !bypass;
    end

    // Next-state logic for the memory request FSM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!miss && (count < CW'(DEPTH)))
                    state_nxt = FETCH;
            end
            FETCH: begin
                if (mem_ack)
                    state_nxt = IDLE;
                else if (miss)
                    state_nxt = DISCARD;
            end
            DISCARD: begin
                if (mem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        cpu_inst_valid = 1'b0;
        cpu_data1      = '0;
        mem_readM1     = Reset_N && (state != IDLE);
        mem_address1   = mem_readM1 ? req_addr : '0;
        num_flush      = flush_cnt;
        if (Reset_N) begin
            if (bypass) begin
                cpu_inst_valid = 1'b1;
                cpu_data1      = mem_data1;
            end else if (hit) begin
                cpu_inst_valid = 1'b1;
                cpu_data1      = fifo_data[head];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Pointers, occupancy, fetch address and flush counter.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fetch_pc  <= '0;
            req_addr  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == IDLE && state_nxt == FETCH)
                req_addr <= fetch_pc;
            if (miss) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= cpu_address1;
                if (flush_cnt != '1)
                    flush_cnt <= flush_cnt + WORD_SIZE'(1);
            end else begin
                if (hit)
                    head <= head + AW'(1);
                if (push)
                    tail <= tail + AW'(1);
                if (push && !hit)
                    count <= count + CW'(1);
                else if (hit && !push)
                    count <= count - CW'(1);
                if (take)
                    fetch_pc <= fetch_pc + WORD_SIZE'(1);
            end
        end
    end

    // Entry storage; a push never targets a live slot.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_addr[tail] <= fetch_pc;
            fifo_data[tail] <= mem_data1;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Randomized bench for inst_prefetch_buffer with a queue-based reference model.
// Directed scenarios cover ordered fetch, fill, flush, discard, wrap and reset.
module tb_inst_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_rd;
    logic [W-1:0] cpu_a;
    logic [W-1:0] cpu_d;
    logic         cpu_v;
    logic         mem_rd;
    logic [W-1:0] mem_a;
    logic [W-1:0] mem_d;
    logic         mem_ack;
    logic [W-1:0] flushes;

    always #5 clk = ~clk;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .WORD_SIZE(W)) dut (
        .Clk            (clk),
        .Reset_N        (rst_n),
        .cpu_readM1     (cpu_rd),
        .cpu_address1   (cpu_a),
        .cpu_data1      (cpu_d),
        .cpu_inst_valid (cpu_v),
        .mem_readM1     (mem_rd),
        .mem_address1   (mem_a),
        .mem_data1      (mem_d),
        .mem_ack        (mem_ack),
        .num_flush      (flushes)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } ent_t;

    int total = 0;
    int bad   = 0;

    ent_t         mq[$];
    logic [W-1:0] m_pc;
    logic [W-1:0] m_req;
    logic [W-1:0] m_flush;
    bit           m_busy;
    bit           m_drop;
    int           lat_left;
    int           lat_mode;
    bit           stray_en;
    bit           stray_once;
    bit           obs_valid;
    logic [W-1:0] obs_data;
    logic [W-1:0] fetched[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = '0;
        m_req    = '0;
        m_flush  = '0;
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        lat_left = 0;
    endtask

    // One clock cycle: entered and left #1 after a rising edge.
    task automatic tick(input bit rd, input logic [W-1:0] a);
        bit           ack, hit, wt, miss, byp, was_busy;
        logic [W-1:0] md;
        int           sz;
        chk("mem_readM1", 32'(mem_rd), 32'(m_busy));
        chk("mem_address1", 32'(mem_a), m_busy ? 32'(m_req) : 32'h0);
        chk("num_flush", 32'(flushes), 32'(m_flush));
        ack = m_busy && (lat_left == 0);
        if (!m_busy && stray_en && $urandom_range(0, 3) == 0)
            ack = 1'b1;
        if (!m_busy && stray_once)
            ack = 1'b1;
        stray_once = 1'b0;
        md = (m_busy && ack) ? (m_req ^ 16'hA5A5) : W'($urandom);
        cpu_rd  = rd;
        cpu_a   = a;
        mem_ack = ack;
        mem_d   = md;
        #1;
        sz   = mq.size();
        hit  = rd && sz > 0 && mq[0].a == a;
        wt   = rd && sz == 0 && a == m_pc;
        miss = rd && !hit && !wt;
        byp  = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        byp  = m_busy && !m_drop && ack && wt;
`endif
        obs_valid = cpu_v;
        obs_data  = cpu_d;
        chk("cpu_inst_valid", 32'(cpu_v), 32'(hit || byp));
        chk("cpu_data1", 32'(cpu_d),
            hit ? 32'(mq[0].d) : (byp ? 32'(md) : 32'h0));
        was_busy = m_busy;
        if (hit)
            void'(mq.pop_front());
        if (m_busy && ack) begin
            if (!m_drop && !miss) begin
                if (!byp)
                    mq.push_back('{a: m_pc, d: md});
                fetched.push_back(m_pc);
                m_pc++;
            end
            m_busy = 1'b0;
            m_drop = 1'b0;
        end else if (m_busy) begin
            lat_left--;
        end
        if (miss) begin
            mq.delete();
            m_pc = a;
            if (m_flush != 16'hFFFF)
                m_flush++;
            if (m_busy)
                m_drop = 1'b1;
        end
        if (!was_busy && !miss && sz < DEPTH) begin
            m_busy   = 1'b1;
            m_req    = m_pc;
            lat_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst_n   = 1'b0;
            cpu_rd  = 1'($urandom);
            cpu_a   = W'($urandom);
            mem_ack = 1'($urandom);
            mem_d   = W'($urandom);
            #1;
            chk("rst_mem_readM1", 32'(mem_rd), 32'h0);
            chk("rst_mem_address1", 32'(mem_a), 32'h0);
            chk("rst_cpu_inst_valid", 32'(cpu_v), 32'h0);
            chk("rst_cpu_data1", 32'(cpu_d), 32'h0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic req_until(input logic [W-1:0] a, output bit got,
                             output logic [W-1:0] d);
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, a);
            if (obs_valid) begin
                got = 1'b1;
                d   = obs_data;
                return;
            end
        end
    endtask

    task automatic wait_mrd(input bit lvl, input string tag);
        int n = 0;
        while (mem_rd !== lvl && n < 20) begin
            tick(1'b0, '0);
            n++;
        end
        chk(tag, 32'(mem_rd), 32'(lvl));
    endtask

    logic [W-1:0] seq_exp [4];
    logic [W-1:0] wrap_a  [3];
    logic [W-1:0] d;
    bit           got;
    int           r;
    logic [W-1:0] a;

    initial begin
        seq_exp    = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
        wrap_a     = '{16'hFFFE, 16'hFFFF, 16'h0000};
        stray_en   = 1'b0;
        stray_once = 1'b0;
        lat_mode   = 1;
        rst_n      = 1'b0;
        model_reset();

        // ordered fetch of 0..3 with one-cycle memory latency
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            req_until(W'(k), got, d);
            chk("seq_hit", 32'(got), 32'h1);
            chk("seq_data", 32'(d), 32'(seq_exp[k]));
        end
        chk("seq_flush", 32'(flushes), 32'h0);

        // idle CPU fills the FIFO then stops requesting
        do_reset(1);
        fetched.delete();
        for (int i = 0; i < 20; i++)
            tick(1'b0, '0);
        chk("fill_count", 32'(fetched.size()), 32'd4);
        for (int i = 0; i < fetched.size(); i++)
            chk("fill_addr", 32'(fetched[i]), 32'(i));
        chk("fill_idle", 32'(mem_rd), 32'h0);

        // miss against a full FIFO
        tick(1'b1, 16'h0040);
        chk("miss_valid", 32'(obs_valid), 32'h0);
        chk("miss_flush", 32'(flushes), 32'h1);
        wait_mrd(1'b1, "miss_req");
        chk("miss_req_addr", 32'(mem_a), 32'h0040);
        req_until(16'h0040, got, d);
        chk("miss_hit", 32'(got), 32'h1);
        chk("miss_data", 32'(d), 32'hA5E5);

        // miss while a slow fetch is outstanding
        lat_mode = 5;
        do_reset(1);
        wait_mrd(1'b1, "disc_start");
        tick(1'b1, 16'h0100);
        chk("disc_valid", 32'(obs_valid), 32'h0);
        chk("disc_mrd", 32'(mem_rd), 32'h1);
        chk("disc_addr", 32'(mem_a), 32'h0);
        wait_mrd(1'b0, "disc_end");
        wait_mrd(1'b1, "disc_next");
        chk("disc_next_addr", 32'(mem_a), 32'h0100);
        req_until(16'h0100, got, d);
        chk("disc_hit", 32'(got), 32'h1);
        chk("disc_data", 32'(d), 32'hA4A5);

        // address wrap after a flush near the top
        lat_mode = -1;
        do_reset(1);
        tick(1'b1, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            req_until(wrap_a[k], got, d);
            chk("wrap_hit", 32'(got), 32'h1);
            chk("wrap_data", 32'(d), 32'(wrap_a[k] ^ 16'hA5A5));
        end
        chk("wrap_flush", 32'(flushes), 32'h1);

        // reset in the middle of a fetch, stray ack afterwards
        lat_mode = 5;
        do_reset(1);
        wait_mrd(1'b1, "rst_fetch");
        do_reset(1);
        chk("rst_after_mrd", 32'(mem_rd), 32'h0);
        stray_once = 1'b1;
        tick(1'b0, '0);
        wait_mrd(1'b1, "rst_req");
        chk("rst_req_addr", 32'(mem_a), 32'h0);
        req_until(16'h0000, got, d);
        chk("rst_hit", 32'(got), 32'h1);
        chk("rst_data", 32'(d), 32'hA5A5);

        // randomized traffic
        lat_mode = -1;
        stray_en = 1'b1;
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset(1);
            r = int'($urandom_range(0, 7));
            if (r < 4)
                a = (mq.size() > 0) ? mq[0].a : m_pc;
            else if (r < 6)
                a = m_pc;
            else if (r == 6)
                a = m_pc + W'($urandom_range(1, 3));
            else
                a = W'($urandom);
            tick($urandom_range(0, 3) != 0, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
